// File: rtl/gate_check_pkg.sv
// Shared FSM encoding and mismatch-mask bit positions for the gate result checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MSK_AND  = 0;
  localparam int unsigned MSK_OR   = 1;
  localparam int unsigned MSK_NAND = 2;
  localparam int unsigned MSK_W    = 3;

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference values for the AND / OR / NAND gate blocks under test.
module gate_golden_model #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_vec,
  input  logic [WIDTH-1:0] b_vec,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic [WIDTH-1:0] exp_and,
  output logic             exp_or,
  output logic             exp_nand
);

  assign exp_and  = a_vec & b_vec;
  assign exp_or   = a_bit | b_bit;
  assign exp_nand = ~(a_bit & b_bit);

endmodule

// File: rtl/gate_result_checker.sv
// Checks sampled gate outputs against golden values over a fixed-length run;
// counts failing vectors and latches the first failure.
module gate_result_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_VEC = 4,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned IDX_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_vec,
  input  logic [WIDTH-1:0] b_vec,
  input  logic [WIDTH-1:0] y_and,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             y_or,
  input  logic             y_nand,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] first_idx,
  output logic [MSK_W-1:0] first_mask
);

  // vec_idx must reach NUM_VEC itself, hence one extra code point
  localparam int unsigned VCNT_W = $clog2(NUM_VEC + 1);
  localparam logic [VCNT_W-1:0] NV       = VCNT_W'(NUM_VEC);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_e              state_q;
  logic [VCNT_W-1:0]   vec_idx_q, vec_idx_d;
  logic                ready_q;
  logic                p_valid_q;
  logic [IDX_W-1:0]    p_idx_q;
  logic [MSK_W-1:0]    p_mask_q, mask_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [IDX_W-1:0]    first_idx_q;
  logic [MSK_W-1:0]    first_mask_q;
  logic                first_seen_q;
  logic                done_q, pass_q;

  logic [WIDTH-1:0]    exp_and;
  logic                exp_or, exp_nand;
  logic                accept, last_commit;

  gate_golden_model #(.WIDTH(WIDTH)) u_golden (
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .exp_and  (exp_and),
    .exp_or   (exp_or),
    .exp_nand (exp_nand)
  );

  assign accept      = (state_q == RUN) && in_valid && ready_q;
  assign last_commit = p_valid_q && (p_idx_q == LAST_IDX);

  // Mismatch mask of the presented vector and saturating error-count update
  always_comb begin
    mask_d           = '0;
    mask_d[MSK_AND]  = (y_and != exp_and);
    mask_d[MSK_OR]   = (y_or != exp_or);
    mask_d[MSK_NAND] = (y_nand != exp_nand);
    vec_idx_d        = vec_idx_q + VCNT_W'(1);
    err_d            = err_q;
    if (p_valid_q && (p_mask_q != '0) && (err_q != CNT_MAX)) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_idx_q    <= '0;
      ready_q      <= 1'b0;
      p_valid_q    <= 1'b0;
      p_idx_q      <= '0;
      p_mask_q     <= '0;
      err_q        <= '0;
      first_idx_q  <= '0;
      first_mask_q <= '0;
      first_seen_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RUN;
            vec_idx_q    <= '0;
            ready_q      <= 1'b1;
            p_valid_q    <= 1'b0;
            err_q        <= '0;
            first_idx_q  <= '0;
            first_mask_q <= '0;
            first_seen_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        RUN: begin
          p_valid_q <= accept;
          if (accept) begin
            vec_idx_q <= vec_idx_d;
            ready_q   <= (vec_idx_d != NV);
            p_idx_q   <= IDX_W'(vec_idx_q);
            p_mask_q  <= mask_d;
          end
          // Commit stage: one cycle behind acceptance
          if (p_valid_q) begin
            err_q <= err_d;
            if ((p_mask_q != '0) && !first_seen_q) begin
              first_seen_q <= 1'b1;
              first_idx_q  <= p_idx_q;
              first_mask_q <= p_mask_q;
            end
            if (last_commit) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_idx  = first_idx_q;
  assign first_mask = first_mask_q;

endmodule
